// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback register file with same-cycle bypass, zero register and sequenced clear
module wb_regfile #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] S3_ALUOUT,
    input  logic [AW-1:0]    S3_WS,
    input  logic             S3_WE,
    input  logic [AW-1:0]    RS,
    input  logic [AW-1:0]    RT,
    input  logic             CLR,
    output logic [WIDTH-1:0] RD_A,
    output logic [WIDTH-1:0] RD_B,
    output logic             BUSY,
    output logic [15:0]      WR_CNT
);

    localparam int            DEPTH    = 1 << AW;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ZERO_SEL = '0;
    localparam logic [15:0]   CNT_MAX  = 16'hFFFF;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [AW-1:0]    clr_idx;
    logic [AW-1:0]    clr_idx_next;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             busy;
    logic             clr_start;
    logic             commit;
    logic             bypass_a;
    logic             bypass_b;

    // A clear request seen in IDLE wins over a coincident writeback; writes
    // are also locked out for the whole sweep so no stale data survives it.
    assign busy      = (state == CLEAR);
    assign clr_start = (state == IDLE) && CLR;
    assign commit    = S3_WE && !busy && !clr_start && (S3_WS != ZERO_SEL);
    assign bypass_a  = S3_WE && !busy && (S3_WS == RS) && (RS != ZERO_SEL);
    assign bypass_b  = S3_WE && !busy && (S3_WS == RT) && (RT != ZERO_SEL);

    assign BUSY = busy;

    // Clear sequencer state and sweep index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            clr_idx <= '0;
        end else begin
            state   <= state_next;
            clr_idx <= clr_idx_next;
        end
    end

    // Clear sequencer next state: sweep entries 1..DEPTH-1, one per cycle.
    always_comb begin
        state_next   = state;
        clr_idx_next = clr_idx;
        case (state)
            IDLE: begin
                if (CLR) begin
                    state_next   = CLEAR;
                    clr_idx_next = AW'(1);
                end
            end
            CLEAR: begin
                if (clr_idx == LAST_IDX) begin
                    state_next   = IDLE;
                    clr_idx_next = '0;
                end else begin
                    clr_idx_next = clr_idx + AW'(1);
                end
            end
            default: begin
                state_next   = IDLE;
                clr_idx_next = '0;
            end
        endcase
    end

    // Storage: the clear sweep owns the write port while busy; entry 0 is
    // never targeted because the sweep starts at 1 and commits skip it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (busy) begin
            mem[clr_idx] <= '0;
        end else if (commit) begin
            mem[S3_WS] <= S3_ALUOUT;
        end
    end

    // Committed-write counter; survives software clear, saturates at max.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WR_CNT <= '0;
        end else if (commit && (WR_CNT != CNT_MAX)) begin
            WR_CNT <= WR_CNT + 16'd1;
        end
    end

    // Read ports: zero register, then writeback bypass, then storage.
    always_comb begin
        RD_A = '0;
        RD_B = '0;
        if (RS != ZERO_SEL) begin
            RD_A = bypass_a ? S3_ALUOUT : mem[RS];
        end
        if (RT != ZERO_SEL) begin
            RD_B = bypass_b ? S3_ALUOUT : mem[RT];
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - vector table, directed clear/reset sequences and randomized model check for wb_regfile
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic [31:0] s3_aluout;
    logic [4:0]  s3_ws;
    logic        s3_we;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        clr;
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic        busy;
    logic [15:0] wr_cnt;

    int total = 0;
    int bad   = 0;

    wb_regfile #(.WIDTH(32), .AW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .S3_ALUOUT (s3_aluout),
        .S3_WS     (s3_ws),
        .S3_WE     (s3_we),
        .RS        (rs),
        .RT        (rt),
        .CLR       (clr),
        .RD_A      (rd_a),
        .RD_B      (rd_b),
        .BUSY      (busy),
        .WR_CNT    (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: register contents, pending clear work and write count.
    logic [31:0] m_mem [32];
    int          m_clear_left;
    int          m_clear_next;
    int          m_cnt;

    typedef struct {
        logic        we;
        logic [4:0]  ws;
        logic [31:0] data;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic        exp_busy;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_clear_left = 0;
        m_clear_next = 0;
        m_cnt        = 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] sel);
        if (sel == 0) return '0;
        if (s3_we && m_clear_left == 0 && s3_ws == sel) return s3_aluout;
        return m_mem[sel];
    endfunction

    function automatic void model_edge();
        if (!rst) return;
        if (m_clear_left > 0) begin
            m_mem[m_clear_next] = '0;
            m_clear_next++;
            m_clear_left--;
        end else if (clr) begin
            m_clear_left = 31;
            m_clear_next = 1;
        end else if (s3_we && s3_ws != 0) begin
            m_mem[s3_ws] = s3_aluout;
            if (m_cnt < 65535) m_cnt++;
        end
    endfunction

    task automatic model_compare(input string tag);
        check({tag, "_rd_a"}, rd_a, model_read(rs));
        check({tag, "_rd_b"}, rd_b, model_read(rt));
        check({tag, "_busy"}, {31'd0, busy}, {31'd0, m_clear_left > 0});
        check({tag, "_cnt"}, {16'd0, wr_cnt}, m_cnt[31:0]);
    endtask

    // Entered at posedge+1 with inputs set; optional compare at posedge+4.
    task automatic tick(input bit do_chk, input string tag);
        #3;
        if (do_chk) model_compare(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        s3_we = 1'b0; clr = 1'b0;
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    int busy_cycles;
    int rnd;

    initial begin
        rst = 1'b0; s3_aluout = '0; s3_ws = '0; s3_we = 1'b0;
        rs = '0; rt = '0; clr = 1'b0;
        model_reset();

        // Reset holds state even with a valid-looking writeback for 3 edges.
        s3_we = 1'b1; s3_ws = 5'd5; s3_aluout = 32'hDEAD_BEEF; rs = 5'd5; rt = 5'd5;
        repeat (3) begin @(posedge clk); #1; end
        s3_we = 1'b0;
        #1;
        check("rst_rd_a", rd_a, 32'h0);
        check("rst_rd_b", rd_b, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        check("rst_cnt",  {16'd0, wr_cnt}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Write/read/bypass vectors; expectations sampled before each edge.
        vecs[0] = '{1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd0, 32'h1234_5678, 32'h0,         1'b0, 16'd0};
        vecs[1] = '{1'b1, 5'd0, 32'hFFFF_FFFF, 5'd7, 5'd0, 32'h1234_5678, 32'h0,         1'b0, 16'd1};
        vecs[2] = '{1'b0, 5'd9, 32'hA5A5_A5A5, 5'd9, 5'd9, 32'h0,         32'h0,         1'b0, 16'd1};
        vecs[3] = '{1'b1, 5'd9, 32'hA5A5_A5A5, 5'd9, 5'd9, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 16'd1};
        vecs[4] = '{1'b0, 5'd0, 32'h0,         5'd9, 5'd7, 32'hA5A5_A5A5, 32'h1234_5678, 1'b0, 16'd2};
        vecs[5] = '{1'b1, 5'd7, 32'h0BAD_F00D, 5'd0, 5'd7, 32'h0,         32'h0BAD_F00D, 1'b0, 16'd2};
        vecs[6] = '{1'b0, 5'd0, 32'h0,         5'd7, 5'd31, 32'h0BAD_F00D, 32'h0,        1'b0, 16'd3};
        for (int i = 0; i < 7; i++) begin
            s3_we = vecs[i].we; s3_ws = vecs[i].ws; s3_aluout = vecs[i].data;
            rs = vecs[i].ra; rt = vecs[i].rb;
            #3;
            check($sformatf("vec%0d_rd_a", i), rd_a, vecs[i].exp_a);
            check($sformatf("vec%0d_rd_b", i), rd_b, vecs[i].exp_b);
            check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].exp_busy});
            check($sformatf("vec%0d_cnt", i),  {16'd0, wr_cnt}, {16'd0, vecs[i].exp_cnt});
            @(posedge clk);
            model_edge();
            #1;
        end

        // Clear: fill r1..r31, then clear with colliding writes and a repeat CLR.
        do_reset();
        for (int i = 1; i < 32; i++) begin
            s3_we = 1'b1; s3_ws = 5'(i); s3_aluout = 32'(i); rs = 5'(i); rt = 5'(i);
            tick(1'b1, "fill");
        end
        s3_we = 1'b0; rs = 5'd17; rt = 5'd31;
        #1;
        check("fill_cnt", {16'd0, wr_cnt}, 32'd31);
        check("fill_r17", rd_a, 32'd17);
        s3_we = 1'b1; s3_ws = 5'd3; s3_aluout = 32'hFFFF_0003; rs = 5'd3; rt = 5'd4;
        clr = 1'b1;
        @(posedge clk); model_edge(); #1;
        clr = 1'b0;
        busy_cycles = 0;
        for (int c = 0; c < 40; c++) begin
            #3;
            if (!busy) break;
            busy_cycles++;
            check("clr_rd_a_no_bypass", rd_a, model_read(rs));
            check("clr_cnt_frozen", {16'd0, wr_cnt}, 32'd31);
            @(posedge clk); model_edge(); #1;
            clr = (c == 5);
        end
        clr = 1'b0;
        check("clr_busy_cycles", busy_cycles, 31);
        s3_we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs = 5'(i); rt = 5'(31 - i);
            #1;
            check("post_clr_rd_a", rd_a, 32'h0);
            check("post_clr_rd_b", rd_b, 32'h0);
        end
        check("post_clr_cnt", {16'd0, wr_cnt}, 32'd31);
        @(posedge clk); #1;

        // Randomized traffic against the model, with occasional clears.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rnd = $urandom_range(0, 3);
            s3_we = $urandom_range(0, 1);
            s3_ws = 5'($urandom_range(0, 31));
            s3_aluout = $urandom;
            rs = (rnd == 0) ? s3_ws : 5'($urandom_range(0, 31));
            rt = (rnd == 1) ? s3_ws : 5'($urandom_range(0, 31));
            clr = ($urandom_range(0, 149) == 0);
            tick(1'b1, "rand");
        end
        clr = 1'b0;

        // Saturation, then reset partway through a clear.
        do_reset();
        s3_we = 1'b1; s3_ws = 5'd1;
        for (int i = 0; i < 65540; i++) begin
            s3_aluout = 32'(i) | 32'h1;
            tick(1'b0, "sat");
            if (i == 65533) check("sat_cnt_fffe", {16'd0, wr_cnt}, 32'h0000_FFFE);
        end
        check("sat_cnt_ffff", {16'd0, wr_cnt}, 32'h0000_FFFF);
        s3_we = 1'b0; rs = 5'd1; rt = 5'd2;
        #1;
        check("sat_r1_nonzero", {31'd0, rd_a != 0}, 32'd1);
        clr = 1'b1;
        tick(1'b0, "mid");
        clr = 1'b0;
        repeat (10) tick(1'b0, "mid");
        check("mid_busy_before_rst", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        model_reset();
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'h0);
        check("mid_rst_cnt", {16'd0, wr_cnt}, 32'h0);
        check("mid_rst_r1", rd_a, 32'h0);
        s3_we = 1'b1; s3_ws = 5'd5; s3_aluout = 32'h5555_5555;
        repeat (2) tick(1'b0, "held");
        s3_we = 1'b0; rs = 5'd5; rt = 5'd20;
        #1;
        check("held_r5", rd_a, 32'h0);
        check("held_r20", rd_b, 32'h0);
        check("held_cnt", {16'd0, wr_cnt}, 32'h0);
        rst = 1'b1;
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Register file terminating the writeback end of the pipelined datapath: it consumes the stage-3 writeback bundle (result, destination select, write enable) and supplies the two source operands for decode. Includes same-cycle write-to-read bypass, hardwired-zero register 0, and a sequenced software clear with a busy flag.

## Interface
- WIDTH, 32, data width of each register and of the writeback result
- AW, 5, address width; the file holds 2^AW entries
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0); async assert, release synchronized by the integrator
- S3_ALUOUT  in  WIDTH  writeback data from stage 3
- S3_WS  in  AW  writeback destination select
- S3_WE  in  1  writeback enable
- RS  in  AW  read select, port A
- RT  in  AW  read select, port B
- CLR  in  1  clear request (single-cycle pulse or level)
- RD_A  out  WIDTH  port A read data (combinational)
- RD_B  out  WIDTH  port B read data (combinational)
- BUSY  out  1  clear sequence in progress
- WR_CNT  out  16  count of committed writes, saturating

## Operation
- Storage: 2^AW entries of WIDTH bits; entry 0 is never written and always reads 0.
- Commit: on rising clk with rst high, BUSY low, S3_WE=1 and S3_WS≠0, entry[S3_WS] ← S3_ALUOUT and WR_CNT increments (saturates at 16'hFFFF).
- S3_WE=1 with S3_WS=0: no write, no count.
- Read: RD_A = (RS==0) ? 0 : (bypass_A ? S3_ALUOUT : entry[RS]); same for RD_B with RT.
- bypass_A = S3_WE & ~BUSY & (S3_WS==RS) & (RS≠0); lets decode see the value committed on the same edge.
- Clear FSM, states IDLE and CLEAR:
  - IDLE → CLEAR when CLR=1 at an edge; clear index ← 1, BUSY goes high next cycle.
  - CLEAR: each edge writes 0 to entry[index], index increments; at index = 2^AW−1 the entry is cleared and FSM returns to IDLE. Total 2^AW−1 cycles in CLEAR.
  - CLR while in CLEAR is ignored (no restart).
  - S3 writes while BUSY are dropped, not counted, and not bypassed.
  - Reads during CLEAR return current contents (mix of cleared and stale); consumers must stall on BUSY.
  - CLR sampled in IDLE takes priority over a coincident S3 write: that write is dropped.
- WR_CNT is cleared only by rst, not by CLR.

## Timing
- Reset (rst=0, immediate, no clock needed): all entries 0, FSM IDLE, index 0, BUSY=0, WR_CNT=0; RD_A/RD_B therefore 0 (absent bypass, which is also disabled? no: bypass stays combinational, but writes cannot commit while rst=0).
- During rst=0, no commit occurs regardless of S3_WE.
- Write latency: data visible via storage on the cycle after the edge; visible via bypass in the same cycle S3 presents it.
- Read path purely combinational from RS/RT/S3 inputs and storage; no read latency.
- BUSY: high from the edge after CLR sampled through the final clear edge; low in the cycle after.
- rst asserted mid-clear: immediate return to IDLE, all entries 0.
- WR_CNT updates on the same edge as the commit.

## Test plan
- Reset: drive rst=0 with S3_WE=1, S3_WS=5, S3_ALUOUT=32'hDEAD_BEEF, clock 3 times → all reads 0, WR_CNT=0, BUSY=0.
- Write/read: write 32'h1234_5678 to r7, then RS=7 next cycle → RD_A=32'h1234_5678, WR_CNT=1; write to r0 → RD_A with RS=0 stays 0, WR_CNT unchanged.
- Bypass: S3_WE=1, S3_WS=9, S3_ALUOUT=32'hA5A5_A5A5, RS=RT=9 same cycle → both RD_A and RD_B = 32'hA5A5_A5A5 before the edge; r9 old value 0 with S3_WE=0.
- Clear: fill r1..r31 with index values, pulse CLR → BUSY high for exactly 31 cycles, then all reads 0; WR_CNT retains 31.
- Clear collisions: S3 write to r3 on the CLR sample edge and during BUSY → dropped, WR_CNT unchanged, no bypass seen; second CLR during BUSY does not extend BUSY.
- Saturation and mid-clear reset: 65,540 valid writes → WR_CNT=16'hFFFF; assert rst at clear cycle 10 → BUSY=0 immediately, all entries 0, WR_CNT=0.
